fmul_pipe: RTL

FMUL_PIPE -- requirements
Module: fmul_pipe

---
 rtl/fmul_pipe_if.sv | 28 ++
 rtl/fmul_pipe.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fmul_pipe_if.sv
// Operand/result handshake bundle for fmul_pipe.
// master drives in_valid/x1/x2/out_ready; slave returns in_ready/out_valid/y/ovf/unf.
interface fmul_pipe_if #(
   parameter int EW = 8,
   parameter int MW = 23
);
   localparam int W = 1 + EW + MW;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] x1;
   logic [W-1:0] x2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] y;
   logic         ovf;
   logic         unf;

   modport master (
      output in_valid, x1, x2, out_ready,
      input  in_ready, out_valid, y, ovf, unf
   );

   modport slave (
      input  in_valid, x1, x2, out_ready,
      output in_ready, out_valid, y, ovf, unf
   );
endinterface

// File: rtl/fmul_pipe.sv
// 3-stage floating-point multiplier (no subnormals), valid/ready pipeline.
// Ports: clk, rst (async high), bus (fmul_pipe_if.slave: in_valid/in_ready/x1/x2,
// out_valid/out_ready/y/ovf/unf). Macro FMUL_RNE_EN: round-nearest-even, else truncate.
module fmul_pipe #(
   parameter int EW = 8,
   parameter int MW = 23
) (
   input  logic        clk,
   input  logic        rst,
   fmul_pipe_if.slave  bus
);
   localparam int W  = 1 + EW + MW;
   localparam int EX = EW + 2;
   localparam int PF = 2 * MW + 2;
`ifdef FMUL_RNE_EN
   localparam int LO = 0;
`else
   // Truncation never looks below the kept mantissa, so S2 drops those bits.
   localparam int LO = MW;
`endif
   localparam int PW = PF - LO;

   localparam logic [EW-1:0]        EMAX = '1;
   localparam logic signed [EX-1:0] BIAS = EX'(2 ** (EW - 1) - 1);
   localparam logic signed [EX-1:0] EINF = {2'b00, EMAX};

   logic adv;

   // S1: unpack
   logic                 v1_q, v1_d;
   logic                 s1_q, s1_d;
   logic                 z1_q, z1_d;
   logic                 i1_q, i1_d;
   logic signed [EX-1:0] e1_q, e1_d;
   logic [MW:0]          ma1_q, ma1_d;
   logic [MW:0]          mb1_q, mb1_d;

   // S2: significand product
   logic                 v2_q, v2_d;
   logic                 s2_q, s2_d;
   logic                 z2_q, z2_d;
   logic                 i2_q, i2_d;
   logic signed [EX-1:0] e2_q, e2_d;
   logic [PW-1:0]        p2_q, p2_d;

   // S3: packed result
   logic                 v3_q, v3_d;
   logic [W-1:0]         y_q, y_d;
   logic                 ovf_q, ovf_d;
   logic                 unf_q, unf_d;

   logic [EW-1:0]        ea, eb;
   logic                 norm;
   logic [MW-1:0]        mant, mant_r;
   logic signed [EX-1:0] ef;

   assign adv          = !v3_q || bus.out_ready;
   assign bus.in_ready = adv;

   assign ea    = bus.x1[MW +: EW];
   assign eb    = bus.x2[MW +: EW];
   assign v1_d  = bus.in_valid;
   assign s1_d  = bus.x1[W-1] ^ bus.x2[W-1];
   assign z1_d  = (ea == '0) || (eb == '0);
   assign i1_d  = (ea == EMAX) || (eb == EMAX);
   assign e1_d  = signed'({2'b00, ea}) + signed'({2'b00, eb}) - BIAS;
   assign ma1_d = {1'b1, bus.x1[MW-1:0]};
   assign mb1_d = {1'b1, bus.x2[MW-1:0]};

   assign v2_d = v1_q;
   assign s2_d = s1_q;
   assign z2_d = z1_q;
   assign i2_d = i1_q;
   assign e2_d = e1_q;
   assign p2_d = PW'((PF'(ma1_q) * PF'(mb1_q)) >> LO);

   // Product lies in [1,4); the top bit says it reached 2.0.
   assign norm = p2_q[PF-1-LO];
   assign mant = norm ? p2_q[PF-2-LO -: MW]
                      : p2_q[PF-3-LO -: MW];

`ifdef FMUL_RNE_EN
   logic g, st, rup, cy;

   assign g   = norm ? p2_q[MW] : p2_q[MW-1];
   assign st  = norm ? |p2_q[MW-1:0] : |p2_q[MW-2:0];
   assign rup = g && (st || mant[0]);
   // Carry-out leaves mant_r at zero and bumps the exponent.
   assign {cy, mant_r} = {1'b0, mant} + {{MW{1'b0}}, rup};
   assign ef = e2_q + EX'(norm) + EX'(cy);
`else
   assign mant_r = mant;
   assign ef     = e2_q + EX'(norm);
`endif

   assign v3_d = v2_q;

   always_comb begin
      y_d   = {s2_q, {(W-1){1'b0}}};
      ovf_d = 1'b0;
      unf_d = 1'b0;
      if (z2_q) begin
         y_d = {s2_q, {(W-1){1'b0}}};
      end else if (i2_q || ef >= EINF) begin
         y_d   = {s2_q, EMAX, {MW{1'b0}}};
         ovf_d = 1'b1;
      end else if (ef[EX-1] || ef == '0) begin
         unf_d = 1'b1;
      end else begin
         y_d = {s2_q, ef[EW-1:0], mant_r};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q  <= 1'b0;
         s1_q  <= 1'b0;
         z1_q  <= 1'b0;
         i1_q  <= 1'b0;
         e1_q  <= '0;
         ma1_q <= '0;
         mb1_q <= '0;
         v2_q  <= 1'b0;
         s2_q  <= 1'b0;
         z2_q  <= 1'b0;
         i2_q  <= 1'b0;
         e2_q  <= '0;
         p2_q  <= '0;
         v3_q  <= 1'b0;
         y_q   <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (adv) begin
         v1_q  <= v1_d;
         s1_q  <= s1_d;
         z1_q  <= z1_d;
         i1_q  <= i1_d;
         e1_q  <= e1_d;
         ma1_q <= ma1_d;
         mb1_q <= mb1_d;
         v2_q  <= v2_d;
         s2_q  <= s2_d;
         z2_q  <= z2_d;
         i2_q  <= i2_d;
         e2_q  <= e2_d;
         p2_q  <= p2_d;
         v3_q  <= v3_d;
         y_q   <= y_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.out_valid = v3_q;
   assign bus.y         = y_q;
   assign bus.ovf       = ovf_q;
   assign bus.unf       = unf_q;
endmodule
